// File: rtl/modshift_preproc_if.sv
// Request/result bundle for modshift_preproc: operands and start in, result and status out.
// No backpressure: the requester pulses start and watches ready; start is dropped unless the block is idle.
interface modshift_preproc_if #(
   parameter int WIDTH = 256,
   parameter int K_W   = 10
);
   logic             start;
   logic [WIDTH-1:0] M;
   logic [WIDTH-1:0] N;
   logic [K_W-1:0]   K;
   logic [WIDTH-1:0] V;
   logic             ready;
   logic             busy;
   logic             err;

   modport master (
      output start, M, N, K,
      input  V, ready, busy, err
   );

   modport slave (
      input  start, M, N, K,
      output V, ready, busy, err
   );
endinterface

// File: rtl/modshift_preproc.sv
// Computes V = M*2^K mod N by one modular doubling per cycle; ready pulses K+1 cycles after start (1 if K==0 or N==0).
// No backpressure: start is only honoured in IDLE, and V holds until the next accepted request.
module modshift_preproc #(
   parameter int WIDTH = 256,
   parameter int K_W   = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   modshift_preproc_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] n_q;
   logic [K_W-1:0]   k_q;
   logic [K_W-1:0]   cnt_q;
   logic [WIDTH-1:0] v_q;
   logic             ready_q;
   logic             busy_q;
   logic             err_q;

   logic [WIDTH:0]   t_d;
   logic [WIDTH:0]   n_ext_d;
   logic [WIDTH:0]   diff_d;
   logic [WIDTH-1:0] dbl_d;
   logic [WIDTH-1:0] red_d;

   // Doubling keeps the carry bit so the compare against N sees the full WIDTH+1-bit value.
   always_comb begin
      t_d     = {v_q, 1'b0};
      n_ext_d = {1'b0, n_q};
      diff_d  = t_d - n_ext_d;
      dbl_d   = t_d[WIDTH-1:0];
      if (t_d >= n_ext_d) begin
         dbl_d = diff_d[WIDTH-1:0];
      end
      red_d = m_q;
      if (m_q >= n_q) begin
         red_d = m_q - n_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         n_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         v_q     <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               if (bus.start) begin
                  m_q     <= bus.M;
                  n_q     <= bus.N;
                  k_q     <= bus.K;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= INIT;
               end
            end
            INIT: begin
               if (n_q == '0) begin
                  v_q     <= '0;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  v_q   <= red_d;
                  cnt_q <= k_q;
                  if (k_q == '0) begin
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               v_q   <= dbl_d;
               cnt_q <= cnt_q - K_W'(1);
               if (cnt_q == K_W'(1)) begin
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.V     = v_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_modshift_preproc.sv
// Directed and random checks of modshift_preproc at WIDTH=8 and WIDTH=256 against a (M << K) % N reference.
module tb_modshift_preproc;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   modshift_preproc_if #(.WIDTH(8),   .K_W(10)) b8   ();
   modshift_preproc_if #(.WIDTH(256), .K_W(10)) b256 ();

   modshift_preproc #(.WIDTH(8),   .K_W(10)) u_dut8   (.clk(clk), .rst_n(rst_n), .bus(b8));
   modshift_preproc #(.WIDTH(256), .K_W(10)) u_dut256 (.clk(clk), .rst_n(rst_n), .bus(b256));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run8(input string tag, input logic [7:0] m, input logic [7:0] n, input int k);
      logic [63:0] w;
      logic [7:0]  expv;
      int          edges, bcnt, exp_edges;
      bit          got;
      w         = 64'(m) << k;
      expv      = (n == 8'd0) ? 8'd0 : 8'(w % 64'(n));
      exp_edges = (n == 8'd0 || k == 0) ? 1 : k + 1;
      b8.M = m; b8.N = n; b8.K = 10'(k); b8.start = 1'b1;
      tick;
      b8.start = 1'b0;
      b8.M = ~m; b8.N = ~n; b8.K = 10'(k + 3);
      check({tag, "_busy_at_accept"}, 256'(b8.busy), 256'(1));
      check({tag, "_err_cleared"}, 256'(b8.err), 256'(0));
      edges = 0; bcnt = 1; got = 1'b0;
      while (!got && edges < exp_edges + 4) begin
         tick;
         edges++;
         if (b8.ready) got = 1'b1;
         else if (b8.busy) bcnt++;
      end
      check({tag, "_ready_seen"}, 256'(got), 256'(1));
      check({tag, "_latency"}, 256'(edges), 256'(exp_edges));
      check({tag, "_busy_cycles"}, 256'(bcnt), 256'(exp_edges));
      check({tag, "_V"}, 256'(b8.V), 256'(expv));
      check({tag, "_err"}, 256'(b8.err), 256'(n == 8'd0));
      check({tag, "_busy_at_ready"}, 256'(b8.busy), 256'(0));
      tick;
      check({tag, "_ready_pulse"}, 256'(b8.ready), 256'(0));
      check({tag, "_V_hold"}, 256'(b8.V), 256'(expv));
      check({tag, "_err_hold"}, 256'(b8.err), 256'(n == 8'd0));
   endtask

   task automatic run256(input string tag, input logic [255:0] m, input logic [255:0] n, input int k);
      logic [1023:0] w;
      logic [255:0]  expv;
      int            edges;
      bit            got;
      w    = 1024'(m) << k;
      expv = 256'(w % 1024'(n));
      b256.M = m; b256.N = n; b256.K = 10'(k); b256.start = 1'b1;
      tick;
      b256.start = 1'b0;
      b256.M = ~m; b256.N = ~n;
      edges = 0; got = 1'b0;
      while (!got && edges < k + 6) begin
         tick;
         edges++;
         if (b256.ready) got = 1'b1;
      end
      check({tag, "_latency"}, 256'(edges), 256'((k == 0) ? 1 : k + 1));
      check({tag, "_V"}, b256.V, expv);
      tick;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      int           rcnt, redge, nn, kk;
      logic [7:0]   vat;
      logic [255:0] n256;
      b8.start = 1'b0;   b8.M = '0;   b8.N = '0;   b8.K = '0;
      b256.start = 1'b0; b256.M = '0; b256.N = '0; b256.K = '0;

      #1;
      check("rst_V", 256'(b8.V), 256'(0));
      check("rst_ready", 256'(b8.ready), 256'(0));
      check("rst_busy", 256'(b8.busy), 256'(0));
      check("rst_err", 256'(b8.err), 256'(0));
      check("rst_V256", b256.V, 256'(0));
      tick;
      tick;
      rst_n = 1'b1;

      run8("basic", 8'd5, 8'd13, 8);
      run8("k0_reduce", 8'd20, 8'd13, 0);
      run8("n_zero", 8'd9, 8'd0, 5);
      run8("after_err", 8'd5, 8'd13, 8);
      run8("wide_cmp", 8'd200, 8'd201, 5);
      run8("n255", 8'd254, 8'd255, 12);
      run8("n1", 8'd1, 8'd1, 3);

      // Re-pulsed start mid-run and in the DONE cycle must be ignored.
      b8.M = 8'd5; b8.N = 8'd13; b8.K = 10'd8; b8.start = 1'b1;
      tick;
      rcnt = 0; redge = 0; vat = '0;
      for (int e = 1; e <= 10; e++) begin
         b8.start = (e == 3 || e == 9);
         b8.M     = (e == 3 || e == 9) ? 8'd1 : 8'd5;
         tick;
         if (b8.ready) begin
            rcnt++;
            redge = e;
            vat   = b8.V;
         end
      end
      b8.start = 1'b0;
      check("repulse_ready_count", 256'(rcnt), 256'(1));
      check("repulse_ready_edge", 256'(redge), 256'(9));
      check("repulse_V", 256'(vat), 256'(6));
      check("repulse_V_hold", 256'(b8.V), 256'(6));
      run8("repulse_next", 8'd1, 8'd13, 2);

      for (int i = 0; i < 30; i++) begin
         nn = $urandom_range(1, 255);
         kk = $urandom_range(0, 20);
         run8("rand8", 8'($urandom_range(0, (2 * nn - 1 > 255) ? 255 : 2 * nn - 1)), 8'(nn), kk);
      end

      // Reset mid-run aborts everything at once, with no later ready.
      b8.M = 8'd5; b8.N = 8'd13; b8.K = 10'd8; b8.start = 1'b1;
      tick;
      b8.start = 1'b0;
      tick; tick; tick;
      rst_n = 1'b0;
      #1;
      check("midrst_V", 256'(b8.V), 256'(0));
      check("midrst_busy", 256'(b8.busy), 256'(0));
      check("midrst_ready", 256'(b8.ready), 256'(0));
      tick;
      check("midrst_hold_ready", 256'(b8.ready), 256'(0));
      tick;
      rst_n = 1'b1;
      run8("post_rst", 8'd5, 8'd13, 8);

      n256 = {256{1'b1}};
      run256("w256_max", n256 - 256'd1, n256, 256);
      run256("w256_k0", 256'd5, 256'd13, 0);
      for (int i = 0; i < 150; i++) begin
         n256 = rand256() | 256'd1;
         run256("w256_rand", rand256() % n256, n256, 256);
      end
      for (int i = 0; i < 10; i++) begin
         n256 = rand256() | 256'd1;
         run256("w256_randk", rand256() % n256, n256, $urandom_range(0, 40));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
